miss_msg_det: RTL and testbench

- Gap detector for a MoldUDP64-style receive path. Sits after header parsing and before the retransmission-request logic.
- For each accepted packet header it compares the session ID and sequence number with the values it expects next.
- It flags missing sequence numbers inside a session, or whole missing sessions, together with the replay metadata.
- It then updates its expected state.

---
 rtl/miss_msg_det_pkg.sv | 18 +
 rtl/miss_msg_det_if.sv | 40 ++++
 rtl/miss_msg_det.sv | 98 +++++++++
 tb/tb_miss_msg_det.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/miss_msg_det_pkg.sv
// Shared widths, the session-jump limit and packet classes for the MoldUDP64 gap detector.
package miss_msg_det_pkg;

    localparam int DEF_SEQ_NUM_W = 64;
    localparam int DEF_SID_W     = 80;
    localparam int DEF_ML_W      = 16;

    // Exclusive bound on a forward session jump (2**63).
    localparam logic [DEF_SID_W-1:0] DEF_SID_GAP_MAX = 80'h0000_8000_0000_0000_0000;

    typedef enum logic [1:0] {
        PKT_IDLE,
        PKT_MATCH,
        PKT_FWD,
        PKT_REJECT
    } pkt_class_e;

endpackage

// File: rtl/miss_msg_det_if.sv
// Header-in / miss-report-out bundle between header parser, gap detector and retransmit logic.
interface miss_msg_det_if #(
    parameter int SEQ_NUM_W = 64,
    parameter int SID_W     = 80,
    parameter int ML_W      = 16
);
    import miss_msg_det_pkg::*;

    logic                 v_i;
    logic [SID_W-1:0]     sid_i;
    logic [SEQ_NUM_W-1:0] seq_num_i;
    logic [ML_W-1:0]      msg_cnt_i;
    logic                 eos_i;

    logic                 miss_seq_num_v_o;
    logic [SID_W-1:0]     miss_seq_num_sid_o;
    logic [SEQ_NUM_W-1:0] miss_seq_num_start_o;
    logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o;

    logic                 miss_sid_v_o;
    logic [SID_W-1:0]     miss_sid_start_o;
    logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o;
    logic [SID_W-1:0]     miss_sid_cnt_o;
    logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o;

    modport master (
        output v_i, sid_i, seq_num_i, msg_cnt_i, eos_i,
        input  miss_seq_num_v_o, miss_seq_num_sid_o, miss_seq_num_start_o, miss_seq_num_cnt_o,
        input  miss_sid_v_o, miss_sid_start_o, miss_sid_seq_num_start_o, miss_sid_cnt_o,
        input  miss_sid_seq_num_end_o
    );

    modport slave (
        input  v_i, sid_i, seq_num_i, msg_cnt_i, eos_i,
        output miss_seq_num_v_o, miss_seq_num_sid_o, miss_seq_num_start_o, miss_seq_num_cnt_o,
        output miss_sid_v_o, miss_sid_start_o, miss_sid_seq_num_start_o, miss_sid_cnt_o,
        output miss_sid_seq_num_end_o
    );

endinterface

// File: rtl/miss_msg_det.sv
// Sequence/session gap detector: compares each header against the expected session and
// sequence number, reports gaps combinationally and advances the expectation on accept.
module miss_msg_det
    import miss_msg_det_pkg::*;
#(
    parameter int                   SEQ_NUM_W   = DEF_SEQ_NUM_W,
    parameter int                   SID_W       = DEF_SID_W,
    parameter int                   ML_W        = DEF_ML_W,
    parameter logic [SID_W-1:0]     SID_GAP_MAX = DEF_SID_GAP_MAX
) (
    input  logic         clk,
    input  logic         nreset,
    miss_msg_det_if.slave bus
);

    logic [SID_W-1:0]     r_sid_q;
    logic [SEQ_NUM_W-1:0] r_seq_q;

    pkt_class_e           w_class;
    logic                 w_accept;
    logic [SID_W-1:0]     w_sid_diff;
    logic [SID_W-1:0]     w_sid_nxt;
    logic [SEQ_NUM_W-1:0] w_seq_nxt;

    function automatic logic [SEQ_NUM_W-1:0] next_seq(input logic [SEQ_NUM_W-1:0] seq,
                                                      input logic [ML_W-1:0]      cnt);
        return seq + SEQ_NUM_W'(cnt) + SEQ_NUM_W'(1);
    endfunction

    assign w_sid_diff = bus.sid_i - r_sid_q;

    // Reset gates classification so every output reads 0 while nreset is high.
    always_comb begin
        w_class = PKT_IDLE;
        if (bus.v_i && !nreset) begin
            if (bus.sid_i == r_sid_q) begin
                w_class = (bus.seq_num_i >= r_seq_q) ? PKT_MATCH : PKT_REJECT;
            end else if ((bus.sid_i > r_sid_q) && (w_sid_diff < SID_GAP_MAX)) begin
                w_class = PKT_FWD;
            end else begin
                w_class = PKT_REJECT;
            end
        end
    end

    assign w_accept = (w_class == PKT_MATCH) || (w_class == PKT_FWD);

    always_comb begin
        bus.miss_seq_num_v_o         = 1'b0;
        bus.miss_seq_num_sid_o       = '0;
        bus.miss_seq_num_start_o     = '0;
        bus.miss_seq_num_cnt_o       = '0;
        bus.miss_sid_v_o             = 1'b0;
        bus.miss_sid_start_o         = '0;
        bus.miss_sid_seq_num_start_o = '0;
        bus.miss_sid_cnt_o           = '0;
        bus.miss_sid_seq_num_end_o   = '0;
        case (w_class)
            PKT_MATCH: begin
                if (bus.seq_num_i > r_seq_q) begin
                    bus.miss_seq_num_v_o     = 1'b1;
                    bus.miss_seq_num_sid_o   = r_sid_q;
                    bus.miss_seq_num_start_o = r_seq_q;
                    bus.miss_seq_num_cnt_o   = bus.seq_num_i - r_seq_q;
                end
            end
            PKT_FWD: begin
                bus.miss_sid_v_o             = 1'b1;
                bus.miss_sid_start_o         = r_sid_q;
                bus.miss_sid_seq_num_start_o = r_seq_q;
                bus.miss_sid_cnt_o           = w_sid_diff;
                bus.miss_sid_seq_num_end_o   = bus.seq_num_i;
            end
            default: ;
        endcase
    end

    // End-of-session still reports against the old state, then opens the next session at seq 0.
    always_comb begin
        w_sid_nxt = bus.sid_i;
        w_seq_nxt = next_seq(bus.seq_num_i, bus.msg_cnt_i);
        if (bus.eos_i) begin
            w_sid_nxt = bus.sid_i + SID_W'(1);
            w_seq_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_sid_q <= '0;
            r_seq_q <= '0;
        end else if (w_accept) begin
            r_sid_q <= w_sid_nxt;
            r_seq_q <= w_seq_nxt;
        end
    end

endmodule

// File: tb/tb_miss_msg_det.sv
// Self-checking bench for miss_msg_det: directed vector table, reset corner case and
// randomized packets against an expected-state model.
module tb_miss_msg_det;

    localparam logic [79:0] GAP = 80'h0000_8000_0000_0000_0000;

    typedef struct packed {
        logic        ms_v;
        logic [79:0] ms_sid;
        logic [63:0] ms_start;
        logic [63:0] ms_cnt;
        logic        s_v;
        logic [79:0] s_start;
        logic [63:0] s_ss;
        logic [79:0] s_cnt;
        logic [63:0] s_end;
    } outs_t;

    typedef struct {
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic        eos;
        outs_t       exp;
        logic [79:0] nsid;
        logic [63:0] nseq;
    } vec_t;

    logic clk;
    logic nreset;
    int   checks;
    int   failures;

    logic [79:0] m_sid;
    logic [63:0] m_seq;

    miss_msg_det_if bus ();

    miss_msg_det dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mk_ms(input logic [79:0] sid, input logic [63:0] st, input logic [63:0] c);
        outs_t o = '0;
        o.ms_v = 1'b1; o.ms_sid = sid; o.ms_start = st; o.ms_cnt = c;
        return o;
    endfunction

    function automatic outs_t mk_sid(input logic [79:0] st, input logic [63:0] ss,
                                     input logic [79:0] c, input logic [63:0] e);
        outs_t o = '0;
        o.s_v = 1'b1; o.s_start = st; o.s_ss = ss; o.s_cnt = c; o.s_end = e;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.ms_v     = bus.miss_seq_num_v_o;
        o.ms_sid   = bus.miss_seq_num_sid_o;
        o.ms_start = bus.miss_seq_num_start_o;
        o.ms_cnt   = bus.miss_seq_num_cnt_o;
        o.s_v      = bus.miss_sid_v_o;
        o.s_start  = bus.miss_sid_start_o;
        o.s_ss     = bus.miss_sid_seq_num_start_o;
        o.s_cnt    = bus.miss_sid_cnt_o;
        o.s_end    = bus.miss_sid_seq_num_end_o;
        return o;
    endfunction

    task automatic chk(input string nm, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Drive one header mid-cycle, check the same-cycle outputs, let the edge update state.
    task automatic apply_pkt(input logic v, input logic [79:0] sid, input logic [63:0] seq,
                             input logic [15:0] cnt, input logic eos, input outs_t exp,
                             input string nm);
        @(negedge clk);
        bus.v_i = v; bus.sid_i = sid; bus.seq_num_i = seq; bus.msg_cnt_i = cnt; bus.eos_i = eos;
        #1;
        chk(nm, sample(), exp);
        @(posedge clk);
        #1;
        bus.v_i = 1'b0;
    endtask

    // Non-destructive state read: a one-session jump reports sid_q and seq_q, then v drops before the edge.
    task automatic probe(input logic [79:0] es, input logic [63:0] eq, input string nm);
        bus.v_i = 1'b1; bus.sid_i = es + 80'd1; bus.seq_num_i = 64'h1234;
        bus.msg_cnt_i = '0; bus.eos_i = 1'b0;
        #1;
        chk(nm, sample(), mk_sid(es, eq, 80'd1, 64'h1234));
        bus.v_i = 1'b0;
    endtask

    function automatic void model(input logic v, input logic [79:0] sid, input logic [63:0] seq,
                                  output outs_t o, output logic acc);
        o = '0;
        acc = 1'b0;
        if (v) begin
            if (sid == m_sid) begin
                acc = (seq >= m_seq);
                if (seq > m_seq) o = mk_ms(m_sid, m_seq, seq - m_seq);
            end else if (sid > m_sid && (sid - m_sid) < GAP) begin
                acc = 1'b1;
                o = mk_sid(m_sid, m_seq, sid - m_sid, seq);
            end
        end
    endfunction

    vec_t vecs[12];

    initial begin
        outs_t       eo;
        logic        acc;
        logic        v, eos;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic [95:0] r96;

        checks = 0; failures = 0;
        m_sid = '0; m_seq = '0;

        vecs[0]  = '{80'd0, 64'd0, 16'd5, 1'b0, '0, 80'd0, 64'd6};
        vecs[1]  = '{80'd0, 64'd20, 16'd3, 1'b0, mk_ms(80'd0, 64'd6, 64'd14), 80'd0, 64'd24};
        vecs[2]  = '{80'd1, 64'd90, 16'd9, 1'b0, mk_sid(80'd0, 64'd24, 80'd1, 64'd90), 80'd1, 64'd100};
        vecs[3]  = '{80'd4, 64'd7, 16'd2, 1'b0, mk_sid(80'd1, 64'd100, 80'd3, 64'd7), 80'd4, 64'd10};
        vecs[4]  = '{80'd4, 64'd10, 16'd0, 1'b1, '0, 80'd5, 64'd0};
        vecs[5]  = '{80'd5, 64'd0, 16'd39, 1'b0, '0, 80'd5, 64'd40};
        vecs[6]  = '{80'd4, 64'd3, 16'd1, 1'b0, '0, 80'd5, 64'd40};
        vecs[7]  = '{80'd5, 64'd10, 16'd1, 1'b0, '0, 80'd5, 64'd40};
        vecs[8]  = '{80'h0000_8000_0000_0000_0005, 64'd0, 16'd0, 1'b0, '0, 80'd5, 64'd40};
        vecs[9]  = '{80'd5, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 1'b0,
                     mk_ms(80'd5, 64'd40, 64'hFFFF_FFFF_FFFF_FFD7), 80'd5, 64'd0};
        vecs[10] = '{80'd5, 64'd0, 16'd0, 1'b1, '0, 80'd6, 64'd0};
        vecs[11] = '{80'h0000_8000_0000_0000_0005, 64'd3, 16'd0, 1'b0,
                     mk_sid(80'd6, 64'd0, 80'h0000_7FFF_FFFF_FFFF_FFFF, 64'd3),
                     80'h0000_8000_0000_0000_0005, 64'd4};

        bus.v_i = 1'b1; bus.sid_i = 80'd9; bus.seq_num_i = 64'd50; bus.msg_cnt_i = '0; bus.eos_i = 1'b0;
        nreset = 1'b1;
        #2;
        chk("reset_outputs_init", sample(), '0);
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        nreset = 1'b0;
        probe(80'd0, 64'd0, "reset_state_init");

        for (int i = 0; i < 12; i++) begin
            apply_pkt(1'b1, vecs[i].sid, vecs[i].seq, vecs[i].cnt, vecs[i].eos, vecs[i].exp,
                      $sformatf("vec%0d_out", i));
            probe(vecs[i].nsid, vecs[i].nseq, $sformatf("vec%0d_state", i));
        end

        // Reset asserted while a gap is being reported.
        @(negedge clk);
        bus.v_i = 1'b1; bus.sid_i = 80'h0000_8000_0000_0000_0005; bus.seq_num_i = 64'd100;
        #1;
        chk("gap_before_reset", sample(),
            mk_ms(80'h0000_8000_0000_0000_0005, 64'd4, 64'd96));
        nreset = 1'b1;
        #1;
        chk("reset_outputs_mid", sample(), '0);
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        nreset = 1'b0;
        probe(80'd0, 64'd0, "reset_state_mid");

        m_sid = '0; m_seq = '0;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 9) != 0);
            eos = ($urandom_range(0, 7) == 0);
            cnt = 16'($urandom);
            seq = {$urandom, $urandom};
            sid = m_sid;
            case ($urandom_range(0, 7))
                0: seq = m_seq;
                1: seq = m_seq + 64'($urandom_range(1, 50));
                2: seq = m_seq - 64'($urandom_range(1, 50));
                3: begin sid = m_sid + 80'($urandom_range(1, 3)); seq = 64'($urandom_range(0, 200)); end
                4: sid = m_sid - 80'($urandom_range(1, 3));
                5: begin r96 = {$urandom, $urandom, $urandom}; sid = r96[79:0]; end
                6: sid = m_sid + GAP - 80'($urandom_range(0, 1));
                default: ;
            endcase
            model(v, sid, seq, eo, acc);
            apply_pkt(v, sid, seq, cnt, eos, eo, $sformatf("rnd%0d_out", n));
            if (acc) begin
                if (eos) begin
                    m_sid = sid + 80'd1;
                    m_seq = '0;
                end else begin
                    m_sid = sid;
                    m_seq = seq + 64'(cnt) + 64'd1;
                end
            end
            probe(m_sid, m_seq, $sformatf("rnd%0d_state", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
